booth_mult_sched: RTL and testbench
===================================

// Module: booth_mult_sched
// PURPOSE
// - Round-robin scheduler sharing one pipelined radix-4 Booth multiplier (carry-save sum/carry out) among N_REQ requesters.
// - Issues at most one operand pair per cycle and tags it with the requester id.
// - Resolves sum+carry into the final product and returns it in issue order through a credit-protected result FIFO.
// - Sits between requester datapaths and the multiplier instance; the multiplier itself is external to this block.
// PARAMETERS
// - WIDTH   8  operand width; signed two's complement
// - N_REQ   2  number of requesters, 2..8
// - LAT     3  multiplier latency in CLK cycles, from operands applied to sum/carry valid; >=1
// - DEPTH   4  result FIFO entries, power of two, >=2
// PORTS
// - CLK        in   1             clock, all state on rising edge
// - RST        in   1             synchronous, active-high reset
// - req_valid  in   N_REQ         per-requester operand valid
// - req_ready  out  N_REQ         per-requester accept; one-hot or zero
// - req_x      in   N_REQ*WIDTH   multiplicands; requester i at [i*WIDTH +: WIDTH]
// - req_y      in   N_REQ*WIDTH   multipliers, same packing
// - mul_x      out  WIDTH         operand X to the multiplier (registered)
// - mul_y      out  WIDTH         operand Y to the multiplier (registered)
// - mul_sum    in   2*WIDTH       multiplier sum vector
// - mul_carry  in   2*WIDTH       multiplier carry vector
// - rsp_valid  out  1             result FIFO not empty
// - rsp_ready  in   1             consumer accept
// - rsp_id     out  $clog2(N_REQ) requester id of the head result
// - rsp_p      out  2*WIDTH       signed product of the head result
// - busy       out  1             any op in flight or buffered
// BEHAVIOUR
// - Reset: req_ready=0, mul_x=mul_y=0, rsp_valid=0, rsp_id=0, rsp_p=0, busy=0; RR pointer=0; tag pipe and FIFO emptied.
// - Reset mid-operation: in-flight ops are discarded; sum/carry arriving after reset are ignored (tag valid=0).
// - Credit: credits = DEPTH - fifo_count - inflight. Grant only if credits>0. Pushes/pops in the same cycle are counted as of that cycle's start.
// - Arbitration: round-robin over req_valid, starting at the RR pointer.
//   - The winner g gets req_ready[g]=1 combinationally in the same cycle.
//   - On the handshake edge: mul_x/mul_y <= req_x/y[g], a tag {1,g} enters stage 0 of the LAT-deep tag pipe, and the pointer <= g+1 mod N_REQ.
//   - With no grant, mul_x/mul_y hold their values and a tag {0,-} enters the tag pipe. The pointer holds.
// - Tag stage LAT-1 aligns with mul_sum/mul_carry. When it is valid, the FIFO pushes {id, (mul_sum+mul_carry) mod 2^(2*WIDTH)}.
//   - Sum+carry is done as a 2*WIDTH unsigned add with the carry-out dropped. The result equals the signed product.
// - Throughput 1 op/cycle. Issue-to-rsp_valid latency is LAT+1 cycles when the FIFO is empty.
// - FIFO is first-word-fall-through. Pop on rsp_valid&rsp_ready.
//   - Full: credits keep a push from ever hitting a full FIFO. A push into a full FIFO is an assertion failure.
//   - Empty with a push in the same cycle: rsp_valid rises the next cycle.
//   - Push and pop in the same cycle: count unchanged.
//   - Pointers wrap mod DEPTH.
// - busy = |tag_pipe_valid | (fifo_count!=0).
// STRUCTURE
// - Shared package booth_sched_pkg: WIDTH and id-width constants, tag struct {valid,id}, and the function resolve_cs(sum,carry).
// - One sub-module, booth_sched_fifo: a parameterised FWFT FIFO with count output. The arbiter, credit counter and tag pipe stay inline.
// TESTING
// - Single op: req0 x=8'h07, y=8'hFD -> rsp_p=16'hFFEB (-21), rsp_id=0, LAT+1=4 cycles after the handshake.
// - Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; one result per cycle; ids match.
// - Extremes: x=y=8'h80 -> 16'h4000. x=8'h80, y=8'h7F -> 16'hC080. x=8'hFF, y=8'hFF -> 16'h0001.
// - Backpressure: rsp_ready=0, req0 streaming -> exactly DEPTH=4 handshakes, then req_ready=0. One pop re-opens exactly one grant.
// - Reset with 2 ops in flight -> no rsp_valid afterwards; busy=0 in the cycle after reset; RR pointer restarts at 0.
// - Random: 10000 random signed pairs on random requesters with random rsp_ready -> each product is checked against x*y, and per-requester order is preserved.

Source files
------------

// File: rtl/booth_sched_pkg.sv
// Shared types and helpers for the Booth multiplier scheduler.
// Holds default widths, the tag bundle and the carry-save resolver.
package booth_sched_pkg;

  localparam int B_WIDTH   = 8;
  localparam int B_PW      = 2 * B_WIDTH;
  localparam int B_NREQ    = 2;
  localparam int B_IDW_MAX = 3;

  typedef struct packed {
    logic                 valid;
    logic [B_IDW_MAX-1:0] id;
  } tag_t;

  // Carry-out is dropped on purpose: the wrapped sum is the signed product.
  function automatic logic [B_PW-1:0] resolve_cs(
    input logic [B_PW-1:0] i_sum,
    input logic [B_PW-1:0] i_carry
  );
    return i_sum + i_carry;
  endfunction

endpackage

// File: rtl/booth_sched_fifo.sv
// First-word-fall-through result FIFO with occupancy count.
// Ports: i_clk, i_rst (sync high), i_push/i_data, i_pop, o_valid/o_data, o_count.
module booth_sched_fifo #(
  parameter int DW    = 17,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [DW-1:0]              o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign o_valid = (r_count != '0);
  assign w_pop   = i_pop & o_valid;
  assign o_count = r_count;
  assign o_data  = o_valid ? r_mem[r_rd] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_push) r_mem[r_wr] <= i_data;
  end

  a_no_overflow: assert property (
    @(posedge i_clk) disable iff (i_rst)
    !(i_push && r_count == CNT_W'(DEPTH))
  );

endmodule

// File: rtl/booth_mult_sched.sv
// Round-robin issue of operand pairs to a shared pipelined Booth multiplier.
// Ports: req_* requester side, mul_* multiplier side, rsp_* result side, busy.
module booth_mult_sched
  import booth_sched_pkg::*;
#(
  parameter int WIDTH = B_WIDTH,
  parameter int N_REQ = B_NREQ,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_x,
  input  logic [N_REQ*WIDTH-1:0]   req_y,
  output logic [WIDTH-1:0]         mul_x,
  output logic [WIDTH-1:0]         mul_y,
  input  logic [2*WIDTH-1:0]       mul_sum,
  input  logic [2*WIDTH-1:0]       mul_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]       rsp_p,
  output logic                     busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CW    = $clog2(DEPTH + LAT + 1) + 1;

  logic [ID_W-1:0]  r_ptr;
  logic [WIDTH-1:0] r_mul_x;
  logic [WIDTH-1:0] r_mul_y;
  tag_t             r_tag [LAT];

  logic             w_found;
  logic [ID_W-1:0]  w_gnt_id;
  logic [WIDTH-1:0] w_sel_x;
  logic [WIDTH-1:0] w_sel_y;
  logic [CW-1:0]    w_inflight;
  logic [CW-1:0]    w_used;
  logic             w_credit;
  logic             w_hs;
  logic [CNT_W-1:0] w_count;
  logic             w_push;
  logic [PW-1:0]    w_prod;
  logic [ID_W+PW-1:0] w_push_data;
  logic [ID_W+PW-1:0] w_rsp_data;
  logic             w_unused;

  always_comb begin
    logic [ID_W:0] v_sum;
    w_found  = 1'b0;
    w_gnt_id = '0;
    v_sum    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      v_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (v_sum >= (ID_W+1)'(N_REQ))
        v_sum = v_sum - (ID_W+1)'(N_REQ);
      if (!w_found && req_valid[v_sum[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = v_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt_id == ID_W'(k)) begin
        w_sel_x = req_x[k*WIDTH +: WIDTH];
        w_sel_y = req_y[k*WIDTH +: WIDTH];
      end
    end
  end

  // Stage LAT-1 is still counted even though it pushes this cycle.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++)
      w_inflight = w_inflight + CW'(r_tag[i].valid);
  end

  assign w_used    = w_inflight + CW'(w_count);
  assign w_credit  = (w_used < CW'(DEPTH));
  assign w_hs      = w_found & w_credit & ~RST;
  assign req_ready = w_hs ? (N_REQ'(1) << w_gnt_id) : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr   <= '0;
      r_mul_x <= '0;
      r_mul_y <= '0;
      for (int i = 0; i < LAT; i++)
        r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '0;
      if (w_hs) begin
        r_mul_x  <= w_sel_x;
        r_mul_y  <= w_sel_y;
        r_tag[0] <= '{valid: 1'b1, id: B_IDW_MAX'(w_gnt_id)};
        if (w_gnt_id == ID_W'(N_REQ - 1))
          r_ptr <= '0;
        else
          r_ptr <= w_gnt_id + 1'b1;
      end
      for (int i = 1; i < LAT; i++)
        r_tag[i] <= r_tag[i-1];
    end
  end

  assign mul_x = r_mul_x;
  assign mul_y = r_mul_y;

  assign w_push      = r_tag[LAT-1].valid;
  assign w_prod      = resolve_cs(mul_sum, mul_carry);
  assign w_push_data = {r_tag[LAT-1].id[ID_W-1:0], w_prod};
  assign w_unused    = ^r_tag[LAT-1].id;

  booth_sched_fifo #(
    .DW    (ID_W + PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (rsp_ready),
    .o_valid (rsp_valid),
    .o_data  (w_rsp_data),
    .o_count (w_count)
  );

  assign rsp_id = w_rsp_data[ID_W+PW-1:PW];
  assign rsp_p  = w_rsp_data[PW-1:0];
  assign busy   = (w_inflight != '0) | (w_count != '0);

endmodule

// File: tb/tb_booth_mult_sched.sv
// Directed and random checks for booth_mult_sched.
// Includes a behavioural carry-save multiplier aligned to the tag pipe.
module tb_booth_mult_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [7:0]  mul_x;
  logic [7:0]  mul_y;
  logic [15:0] mul_sum;
  logic [15:0] mul_carry;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_p;
  logic        busy;

  always #5 CLK = ~CLK;

  booth_mult_sched #(
    .WIDTH (8),
    .N_REQ (2),
    .LAT   (3),
    .DEPTH (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_sum   (mul_sum),
    .mul_carry (mul_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic signed [15:0] sp;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    sp = sa * sb;
    return sp;
  endfunction

  logic [7:0]  d1x = '0, d1y = '0, d2x = '0, d2y = '0;
  logic [15:0] dc = '0;
  always @(posedge CLK) begin
    d1x <= mul_x;
    d1y <= mul_y;
    d2x <= d1x;
    d2y <= d1y;
    dc  <= 16'($urandom);
  end
  assign mul_carry = dc;
  assign mul_sum   = smul(d2x, d2y) - dc;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ops(input logic id, input logic [7:0] x,
                         input logic [7:0] y);
    if (id) begin
      req_x[15:8] = x;
      req_y[15:8] = y;
    end else begin
      req_x[7:0] = x;
      req_y[7:0] = y;
    end
  endtask

  task automatic issue(input logic id, input logic [7:0] x, input logic [7:0] y);
    logic ok;
    ok = 1'b0;
    set_ops(id, x, y);
    req_valid[id] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
    end
    check("issue_grant", 32'(ok), 32'd1);
    tick();
    req_valid[id] = 1'b0;
  endtask

  task automatic expect_rsp(input logic id, input logic [15:0] p);
    logic ok;
    ok = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("rsp_seen", 32'(ok), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_p", 32'(rsp_p), 32'(p));
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (!busy) break;
      tick();
    end
    check("drain_idle", 32'(busy), 32'd0);
    rsp_ready = 1'b0;
  endtask

  logic        mon_en = 1'b0;
  logic [16:0] exp_q [$];

  always @(negedge CLK) begin
    if (mon_en) begin
      if (rsp_valid && rsp_ready) begin
        check("rnd_q", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("rnd_id", 32'(rsp_id), 32'(e[16]));
          check("rnd_p", 32'(rsp_p), 32'(e[15:0]));
        end
      end
      if (req_valid[0] && req_ready[0])
        exp_q.push_back({1'b0, smul(req_x[7:0], req_y[7:0])});
      if (req_valid[1] && req_ready[1])
        exp_q.push_back({1'b1, smul(req_x[15:8], req_y[15:8])});
    end
  end

  logic [1:0] hs = '0;

  task automatic rnd_req(input logic id);
    if (!req_valid[id] || hs[id]) begin
      req_valid[id] = 1'($urandom_range(0, 1));
      set_ops(id, 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    int n;
    int issued;
    int cyc;
    logic seen;

    RST       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;

    tick();
    tick();
    req_valid = 2'b11;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_mul_x", 32'(mul_x), 32'd0);
    check("rst_mul_y", 32'(mul_y), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_p", 32'(rsp_p), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    tick();
    RST = 1'b0;

    set_ops(1'b0, 8'h07, 8'hFD);
    req_valid = 2'b01;
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("single_mul_x", 32'(mul_x), 32'h07);
    check("single_mul_y", 32'(mul_y), 32'hFD);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check("single_early", 32'(rsp_valid), 32'd0);
    tick();
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_id", 32'(rsp_id), 32'd0);
    check("single_p", 32'(rsp_p), 32'hFFEB);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("single_idle", 32'(busy), 32'd0);

    issue(1'b0, 8'h80, 8'h80);
    issue(1'b0, 8'h80, 8'h7F);
    issue(1'b0, 8'hFF, 8'hFF);
    expect_rsp(1'b0, 16'h4000);
    expect_rsp(1'b0, 16'hC080);
    expect_rsp(1'b0, 16'h0001);

    set_ops(1'b0, 8'd5, 8'd6);
    req_valid = 2'b01;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (req_ready[0]) n++;
      tick();
    end
    check("bp_grants", 32'(n), 32'd4);
    #1;
    check("bp_closed", 32'(req_ready), 32'd0);
    check("bp_head", 32'(rsp_p), 32'h001E);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (req_ready[0]) n++;
      tick();
    end
    check("bp_reopen", 32'(n), 32'd1);
    req_valid = '0;
    drain();

    issue(1'b0, 8'd3, 8'd3);
    issue(1'b0, 8'd4, 8'd4);
    check("rstmid_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rstmid_busy_after", 32'(busy), 32'd0);
    check("rstmid_valid_after", 32'(rsp_valid), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen = seen | rsp_valid | busy;
    end
    check("rstmid_quiet", 32'(seen), 32'd0);

    set_ops(1'b0, 8'h03, 8'h05);
    set_ops(1'b1, 8'hFE, 8'h07);
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("alt_grant", 32'(req_ready), (k % 2 == 1) ? 32'h2 : 32'h1);
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      check("alt_valid", 32'(rsp_valid), 32'd1);
      check("alt_id", 32'(rsp_id), 32'(k % 2));
      check("alt_p", 32'(rsp_p), (k % 2 == 1) ? 32'hFFF2 : 32'h000F);
      tick();
    end
    check("alt_empty", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;

    mon_en = 1'b1;
    issued = 0;
    cyc    = 0;
    hs     = '0;
    while (issued < 10000 && cyc < 60000) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      rnd_req(1'b0);
      rnd_req(1'b1);
      #1;
      hs = req_valid & req_ready;
      issued += int'(hs[0]) + int'(hs[1]);
      tick();
      cyc++;
    end
    check("rnd_issued", 32'(issued >= 10000), 32'd1);
    req_valid = '0;
    drain();
    check("rnd_left", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
